// File: rtl/sf2000_pkg.sv
// Shared definitions for the turbo-CPU fast-RAM controller: FSM encoding, window constants, strobe bundle.
// SRAM_WR_RECOVERY_EN adds the RECOVER state used after write cycles.
package sf2000_pkg;

    localparam logic [3:0] WIN_BASE      = 4'h2;
    localparam logic [3:0] WIN_SIZE4_TOP = 4'h6;
    localparam logic [3:0] WIN_SIZE8_TOP = 4'hA;
    localparam logic [2:0] CPU_SPACE_FC  = 3'b111;
    localparam int         WS_W          = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_DS,
        ST_ACCESS,
        ST_ACK
`ifdef SRAM_WR_RECOVERY_EN
        , ST_RECOVER
`endif
    } state_t;

    // All fields active low; '1 is the fully idle bus.
    typedef struct packed {
        logic ce_n;
        logic oe_n;
        logic we_n;
        logic ub_n;
        logic lb_n;
        logic dtack_n;
    } sram_ctl_t;

endpackage

// File: rtl/fastram_decode.sv
// Combinational fast-RAM window decode: A[23:20] inside the window selected by JP4, excluding CPU space.
module fastram_decode
    import sf2000_pkg::*;
#(
    parameter logic [3:0] BASE_A23_20 = WIN_BASE,
    parameter logic [3:0] SIZE4_TOP   = WIN_SIZE4_TOP,
    parameter logic [3:0] SIZE8_TOP   = WIN_SIZE8_TOP
) (
    input  logic       jp4,
    input  logic [2:0] fc,
    input  logic [3:0] a,
    output logic       hit
);

    logic [3:0] top;

    assign top = jp4 ? SIZE8_TOP : SIZE4_TOP;
    assign hit = (a >= BASE_A23_20) && (a < top) && (fc != CPU_SPACE_FC);

endmodule

// File: rtl/fastram_ctrl.sv
// Fast-RAM SRAM controller: sequences CE/OE/WE/byte strobes with programmable wait states and returns DTACK.
// Optional SRAM_WR_RECOVERY_EN inserts one CE-high RECOVER cycle after each write.
module fastram_ctrl
    import sf2000_pkg::*;
#(
    parameter int         WAIT_STATES = 1,
    parameter logic [3:0] BASE_A23_20 = WIN_BASE,
    parameter logic [3:0] SIZE4_TOP   = WIN_SIZE4_TOP,
    parameter logic [3:0] SIZE8_TOP   = WIN_SIZE8_TOP
) (
    input  logic       CLKCPU,
    input  logic       RESET_n,
    input  logic       JP4,
    input  logic       AS_CPU_n,
    input  logic       UDS_n,
    input  logic       LDS_n,
    input  logic       RW,
    input  logic [2:0] FC,
    input  logic [3:0] A,
    output logic       FASTRAM_HIT,
    output logic       SRAM_CE_n,
    output logic       SRAM_OE_n,
    output logic       SRAM_WE_n,
    output logic       SRAM_UB_n,
    output logic       SRAM_LB_n,
    output logic       SRAM_DTACK_n
);

    localparam logic [WS_W-1:0] WS_LOAD = WS_W'(WAIT_STATES);

    state_t          state, state_nx;
    logic [WS_W-1:0] cnt, cnt_nx;
    logic            rw_q, rw_nx;
    sram_ctl_t       ctl, ctl_nx;

    fastram_decode #(
        .BASE_A23_20 (BASE_A23_20),
        .SIZE4_TOP   (SIZE4_TOP),
        .SIZE8_TOP   (SIZE8_TOP)
    ) u_decode (
        .jp4 (JP4),
        .fc  (FC),
        .a   (A),
        .hit (FASTRAM_HIT)
    );

    always_ff @(posedge CLKCPU or negedge RESET_n) begin
        if (!RESET_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            rw_q  <= 1'b1;
            ctl   <= '1;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            rw_q  <= rw_nx;
            ctl   <= ctl_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        rw_nx    = rw_q;
        case (state)
            ST_IDLE: begin
                if (!AS_CPU_n && FASTRAM_HIT) begin
                    rw_nx    = RW;
                    state_nx = ST_WAIT_DS;
                end
            end
            ST_WAIT_DS: begin
                if (AS_CPU_n)
                    state_nx = ST_IDLE;
                else if (!UDS_n || !LDS_n) begin
                    state_nx = ST_ACCESS;
                    cnt_nx   = WS_LOAD;
                end
            end
            ST_ACCESS: begin
                if (AS_CPU_n)
                    state_nx = ST_IDLE;
                else if (cnt == '0)
                    state_nx = ST_ACK;
                else
                    cnt_nx = cnt - 1'b1;
            end
            ST_ACK: begin
                if (AS_CPU_n)
`ifdef SRAM_WR_RECOVERY_EN
                    state_nx = rw_q ? ST_IDLE : ST_RECOVER;
`else
                    state_nx = ST_IDLE;
`endif
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Strobes are registered from the next state so every exit path drops them on the same edge.
    always_comb begin
        ctl_nx = '1;
        case (state_nx)
            ST_WAIT_DS: begin
                ctl_nx.ce_n = 1'b0;
                ctl_nx.oe_n = !rw_nx;
            end
            ST_ACCESS: begin
                ctl_nx.ce_n = 1'b0;
                ctl_nx.oe_n = !rw_nx;
                ctl_nx.we_n = rw_nx;
                ctl_nx.ub_n = UDS_n;
                ctl_nx.lb_n = LDS_n;
            end
            ST_ACK: begin
                ctl_nx.ce_n    = 1'b0;
                ctl_nx.oe_n    = !rw_nx;
                ctl_nx.we_n    = rw_nx;
                ctl_nx.dtack_n = 1'b0;
                ctl_nx.ub_n    = (state == ST_ACCESS) ? UDS_n : ctl.ub_n;
                ctl_nx.lb_n    = (state == ST_ACCESS) ? LDS_n : ctl.lb_n;
            end
            default: ctl_nx = '1;
        endcase
    end

    assign SRAM_CE_n    = ctl.ce_n;
    assign SRAM_OE_n    = ctl.oe_n;
    assign SRAM_WE_n    = ctl.we_n;
    assign SRAM_UB_n    = ctl.ub_n;
    assign SRAM_LB_n    = ctl.lb_n;
    assign SRAM_DTACK_n = ctl.dtack_n;

endmodule
